// File: rtl/flash_thermo_encoder.sv
// flash_thermo_encoder
//   Pipelined thermometer-to-binary encoder for the flash ADC back end.
//   Stage 1 registers the raw comparator word, stage 2 applies three-input
//   majority bubble correction, stage 3 priority-encodes the corrected word
//   and produces range/bubble flags plus a saturating bubble-event counter.
//   Fixed latency of 3 clocks, one sample per clock, no backpressure.
//
// Parameters
//   N      output code width (2..6); thermometer width W = 2^N - 1
//   CNT_W  width of the bubble-error counter
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-high reset, clears all state
//   in_valid    comp_in carries a sample this cycle
//   comp_in     [W-1:0] raw comparator outputs (bit i: Vin > reference i)
//   clr_err     synchronous clear of err_count (wins over an increment)
//   out_valid   dout and flags carry a converted sample this cycle
//   dout        [N-1:0] binary code
//   overrange   corrected code is all ones
//   underrange  corrected code is all zeros
//   bubble_err  bubble correction changed at least one bit of this sample
//   err_count   [CNT_W-1:0] saturating count of samples with bubble_err
module flash_thermo_encoder #(
  parameter int N     = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [(2**N)-2:0] comp_in,
  input  logic             clr_err,
  output logic             out_valid,
  output logic [N-1:0]     dout,
  output logic             overrange,
  output logic             underrange,
  output logic             bubble_err,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned W = (2**N) - 1;

  logic [W-1:0] t;
  logic         v1;
  logic [W-1:0] c;
  logic         v2;
  logic         b;

  logic [W+1:0] padded;
  logic [W-1:0] c_next;
  logic [N-1:0] enc;
  logic         all_ones;
  logic         all_zeros;

  // Stage 1: capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t  <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        t <= comp_in;
      end
    end
  end

  // Majority of (t[i-1], t[i], t[i+1]). The word is padded with a 1 below
  // bit 0 and a 0 above bit W-1 so the end bits see a well-formed neighbour.
  always_comb begin
    padded = {1'b0, t, 1'b1};
    c_next = '0;
    for (int unsigned i = 0; i < W; i++) begin
      c_next[i] = (padded[i]   & padded[i+1]) |
                  (padded[i]   & padded[i+2]) |
                  (padded[i+1] & padded[i+2]);
    end
  end

  // Stage 2: correct
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c  <= '0;
      v2 <= 1'b0;
      b  <= 1'b0;
    end else begin
      c  <= c_next;
      v2 <= v1;
      b  <= (c_next != t);
    end
  end

  // Priority encode: highest set bit wins, anything below it is ignored.
  always_comb begin
    enc = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (c[i]) begin
        enc = N'(i + 1);
      end
    end
    all_ones  = &c;
    all_zeros = ~|c;
  end

  // Stage 3: encode; data outputs hold while no sample is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      dout       <= '0;
      overrange  <= 1'b0;
      underrange <= 1'b0;
      bubble_err <= 1'b0;
    end else begin
      out_valid <= v2;
      if (v2) begin
        dout       <= enc;
        overrange  <= all_ones;
        underrange <= all_zeros;
        bubble_err <= b;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (clr_err) begin
      err_count <= '0;
    end else if (v2 && b && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule
